guitar_hero_cpu: RTL and testbench
==================================

# guitar_hero_cpu

Multi-cycle, non-pipelined 32-bit ECE350-style processor core with Guitar Hero I/O extensions. Fetches from an external synchronous instruction ROM, drives an external 32×32 register file, and accesses an external synchronous data RAM. It also samples game inputs (buttons, note intersections, strum, game clock) and publishes a score register to the display logic.

## Interface
Parameters:
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears PC, FSM, score
- address_imem  out  32  PC; ROM uses [11:0]
- q_imem  in  32  ROM word, one cycle after address
- ctrl_writeEnable  out  1  regfile write strobe; never asserted when ctrl_writeReg==0
- ctrl_writeReg  out  5  destination register
- ctrl_readRegA / ctrl_readRegB  out  5 each  regfile read selects
- data_writeReg  out  32  regfile write data
- data_readRegA / data_readRegB  in  32 each  combinational regfile read data
- wren  out  1  RAM write enable
- address_dmem  out  32  RAM address; RAM uses [11:0]
- data  out  32  RAM write data
- q_dmem  in  32  RAM read data, one cycle after address
- buttons  in  4  fret buttons; intersections  in  4  note/target hits; strum  in  1; gameclk  in  1
- score  out  32  current score

## Operation
- Formats: opcode[31:27]; R: rd[26:22] rs[21:17] rt[16:12] shamt[11:7] aluop[6:2]; I: rd rs imm[16:0] sign-extended; JI: T[26:0] zero-extended.
- R-type (opcode 00000) aluop: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll rs by shamt, 00101 sra rs by shamt; others write 0. No overflow exceptions; wrap mod 2^32.
- I/JI: 00101 addi rd=rs+N; 00111 sw MEM[rs+N]=rd; 01000 lw rd=MEM[rs+N]; 00010 bne if rd!=rs PC=PC+1+N; 00110 blt if rd<rs (signed) PC=PC+1+N; 00001 j PC=T; 00011 jal r31=PC+1, PC=T; 00100 jr PC=rd; 10101 setx r30=T; 10110 bex if r30!=0 PC=T.
- Guitar Hero: 11000 gin rd = {22'b0, gameclk, strum, intersections[3:0], buttons[3:0]} (bit0=buttons[0]); 11001 setscore score = $rd.
- Undefined opcodes: no-op, PC=PC+1.
- Read selects: R-type A=rs, B=rt; I-type A=rs, B=rd; jr A=rd; bex A=30; setscore A=rd.
- FSM: FETCH -> EXEC -> (lw/sw) MEM -> (lw) WB -> FETCH.
  - FETCH: address_imem=PC; no writes.
  - EXEC: decode q_imem, compute; ALU/addi/jal/setx/gin assert ctrl_writeEnable; PC and score update on exiting edge; lw/sw latch address and store data, PC=PC+1.
  - MEM: address_dmem=latched addr; sw asserts wren with data=stored $rd; sw returns to FETCH, lw to WB.
  - WB: ctrl_writeEnable=1, data_writeReg=q_dmem.
- ctrl_writeEnable, wren are 0 outside the listed states.

## Timing
- Reset (async): PC=RESET_PC, state=FETCH, score=0, wren=0, ctrl_writeEnable=0. Reset mid-instruction abandons it; no partial write occurs after reset asserts.
- CPI: ALU/branch/jump/I-O 2 cycles; sw 3; lw 4.
- Regfile and RAM write on rising edge while enable is high; ROM/RAM output registered on rising edge (1-cycle latency).
- Game inputs sampled combinationally in the gin EXEC cycle; caller synchronizes them.
- PC wraps mod 2^32; only [11:0] used by ROM.

## Test plan
- Reset then addi r1,r0,5; addi r2,r1,-3 -> r1=5 written cycle 1, r2=2 written cycle 3.
- sub/and/or/sll/sra with r1=-8, shamt 1 -> sll gives -16, sra gives -4, sub r1-r1=0.
- sw r2,4(r0) then lw r3,4(r0) -> r3 equals r2; wren high exactly one cycle.
- bne taken/not taken, blt with -1<1, jal then jr r31 -> correct instructions skipped, r31=PC+1.
- setx 7; bex 20 -> r30=7, PC=20; addi to r0 -> ctrl_writeEnable stays 0.
- buttons=4'b1010, intersections=4'b0011, strum=1, gameclk=0; gin r4; setscore r4 -> r4=0x13A, score=0x13A; reset asserted mid-lw -> score=0, PC=0, no register write.

Source files
------------

// File: rtl/guitar_hero_cpu.sv
// guitar_hero_cpu: multi-cycle ECE350-style core (FETCH/EXEC/MEM/WB)
// with game-input sampling (gin) and a published score register (setscore).
module guitar_hero_cpu #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    output logic        wren,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    input  logic [31:0] q_dmem,
    input  logic [3:0]  buttons,
    input  logic [3:0]  intersections,
    input  logic        strum,
    input  logic        gameclk,
    output logic [31:0] score
);
    localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, WB = 2'd3;
    localparam logic [4:0] OP_R = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010,
        OP_JAL = 5'b00011, OP_JR = 5'b00100, OP_ADDI = 5'b00101, OP_BLT = 5'b00110,
        OP_SW = 5'b00111, OP_LW = 5'b01000, OP_SETX = 5'b10101, OP_BEX = 5'b10110,
        OP_GIN = 5'b11000, OP_SCORE = 5'b11001;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, score_q, score_d, addr_q, addr_d, sdata_q, sdata_d;
    logic [4:0]  ldreg_q, ldreg_d;
    logic        lw_q, lw_d;
    logic [4:0]  op, rd, rs, rt, shamt, aluop, exec_reg;
    logic [31:0] imm, target, a, b, alu, sum, pc1, branch, next_pc, exec_val;
    logic        is_mem, exec_wr, in_exec;
    logic        unused_low;

    assign unused_low = ^q_imem[1:0];
    assign in_exec = state_q == EXEC;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            score_q <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ldreg_q <= '0;
            lw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            score_q <= score_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ldreg_q <= ldreg_d;
            lw_q    <= lw_d;
        end
    end

    // Decode and datapath; instruction word is only valid during EXEC
    always_comb begin
        op     = q_imem[31:27];
        rd     = q_imem[26:22];
        rs     = q_imem[21:17];
        rt     = q_imem[16:12];
        shamt  = q_imem[11:7];
        aluop  = q_imem[6:2];
        imm    = {{15{q_imem[16]}}, q_imem[16:0]};
        target = {5'b0, q_imem[26:0]};
        ctrl_readRegA = (op == OP_JR || op == OP_SCORE) ? rd : op == OP_BEX ? 5'd30 : rs;
        ctrl_readRegB = op == OP_R ? rt : rd;
        a = data_readRegA;
        b = data_readRegB;
        alu = aluop == 5'd0 ? a + b :
              aluop == 5'd1 ? a - b :
              aluop == 5'd2 ? a & b :
              aluop == 5'd3 ? a | b :
              aluop == 5'd4 ? a << shamt :
              aluop == 5'd5 ? $unsigned($signed(a) >>> shamt) : '0;
        sum    = a + imm;
        pc1    = pc_q + 32'd1;
        branch = pc1 + imm;
        next_pc = (op == OP_J || op == OP_JAL) ? target :
                  op == OP_JR ? a :
                  (op == OP_BEX && a != '0) ? target :
                  (op == OP_BNE && b != a) ? branch :
                  (op == OP_BLT && $signed(b) < $signed(a)) ? branch : pc1;
        is_mem   = op == OP_SW || op == OP_LW;
        exec_wr  = op == OP_R || op == OP_ADDI || op == OP_JAL || op == OP_SETX || op == OP_GIN;
        exec_reg = op == OP_JAL ? 5'd31 : op == OP_SETX ? 5'd30 : rd;
        exec_val = op == OP_R ? alu :
                   op == OP_ADDI ? sum :
                   op == OP_JAL ? pc1 :
                   op == OP_SETX ? target :
                   {22'b0, gameclk, strum, intersections, buttons};
    end

    always_comb begin
        state_d = state_q == FETCH ? EXEC :
                  in_exec ? (is_mem ? MEM : FETCH) :
                  (state_q == MEM && lw_q) ? WB : FETCH;
        pc_d    = in_exec ? next_pc : pc_q;
        score_d = (in_exec && op == OP_SCORE) ? a : score_q;
        addr_d  = (in_exec && is_mem) ? sum : addr_q;
        sdata_d = (in_exec && is_mem) ? b : sdata_q;
        ldreg_d = (in_exec && is_mem) ? rd : ldreg_q;
        lw_d    = in_exec ? op == OP_LW : lw_q;
    end

    always_comb begin
        address_imem     = pc_q;
        address_dmem     = addr_q;
        data             = sdata_q;
        score            = score_q;
        ctrl_writeReg    = state_q == WB ? ldreg_q : exec_reg;
        data_writeReg    = state_q == WB ? q_dmem : exec_val;
        ctrl_writeEnable = ((in_exec && exec_wr) || state_q == WB) && ctrl_writeReg != 5'd0;
        wren             = state_q == MEM && !lw_q;
    end
endmodule

// File: tb/tb_guitar_hero_cpu.sv
// tb_guitar_hero_cpu: runs a directed program against an ISA-level model,
// checking every cycle of every instruction, then a mid-lw reset.
module tb_guitar_hero_cpu;
    logic        clock = 1'b0, reset = 1'b1;
    logic [31:0] address_imem, q_imem, data_writeReg, data_readRegA, data_readRegB;
    logic [31:0] address_dmem, data, q_dmem, score;
    logic        ctrl_writeEnable, wren, strum, gameclk;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [3:0]  buttons, intersections;

    logic [31:0] rom [4096];
    logic [31:0] ram [4096];
    logic [31:0] rf  [32];
    logic [31:0] mmem [4096];
    logic [31:0] mrf [32];
    logic [31:0] mpc, mscore, ewval, eaddr, edata;
    logic [4:0]  ewreg;
    int          cpi, ewph, wren_cnt = 0;
    logic        esw;
    int          errs = 0, chks = 0;

    guitar_hero_cpu #(.RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB), .wren(wren), .address_dmem(address_dmem),
        .data(data), .q_dmem(q_dmem), .buttons(buttons),
        .intersections(intersections), .strum(strum), .gameclk(gameclk),
        .score(score)
    );

    always #5 clock = ~clock;

    assign data_readRegA = ctrl_readRegA == 5'd0 ? 32'd0 : rf[ctrl_readRegA];
    assign data_readRegB = ctrl_readRegB == 5'd0 ? 32'd0 : rf[ctrl_readRegB];

    always @(posedge clock) begin
        q_imem <= rom[address_imem[11:0]];
        q_dmem <= ram[address_dmem[11:0]];
        if (wren) begin
            ram[address_dmem[11:0]] <= data;
            wren_cnt <= wren_cnt + 1;
        end
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, sh, fn);
        return {5'b0, rd, rs, rt, sh, fn, 2'b0};
    endfunction
    function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input int imm);
        logic [31:0] v = imm;
        return {op, rd, rs, v[16:0]};
    endfunction
    function automatic logic [31:0] j_ins(input logic [4:0] op, input int t);
        logic [31:0] v = t;
        return {op, v[26:0]};
    endfunction

    // ISA-level reference: executes one instruction on the model state and
    // records which cycle of it should write the regfile or the RAM
    task automatic step(input logic [31:0] ins);
        logic [4:0]  op = ins[31:27], rd = ins[26:22], rs = ins[21:17], rt = ins[16:12];
        logic [4:0]  sh = ins[11:7], fn = ins[6:2];
        logic [31:0] n = {{15{ins[16]}}, ins[16:0]}, t = {5'b0, ins[26:0]};
        logic [31:0] npc = mpc + 1, x = mrf[rs], y = mrf[rt], tmp;
        cpi = 2; ewph = 1; ewreg = 0; ewval = 0; esw = 0; eaddr = 0; edata = 0;
        case (op)
            5'd0: begin
                ewreg = rd;
                case (fn)
                    5'd0: ewval = x + y;
                    5'd1: ewval = x - y;
                    5'd2: ewval = x & y;
                    5'd3: ewval = x | y;
                    5'd4: ewval = x * (32'd1 << sh);
                    5'd5: ewval = $unsigned($signed(x) >>> sh);
                    default: ewval = 0;
                endcase
            end
            5'd5: begin ewreg = rd; ewval = x + n; end
            5'd7: begin
                cpi = 3; esw = 1; eaddr = x + n; edata = mrf[rd];
                mmem[eaddr[11:0]] = edata;
            end
            5'd8: begin cpi = 4; ewph = 3; ewreg = rd; tmp = x + n; ewval = mmem[tmp[11:0]]; end
            5'd2: if (mrf[rd] != x) npc = mpc + 1 + n;
            5'd6: if ($signed(mrf[rd]) < $signed(x)) npc = mpc + 1 + n;
            5'd1: npc = t;
            5'd3: begin ewreg = 31; ewval = mpc + 1; npc = t; end
            5'd4: npc = mrf[rd];
            5'd21: begin ewreg = 30; ewval = t; end
            5'd22: if (mrf[30] != 0) npc = t;
            5'd24: begin ewreg = rd; ewval = {22'b0, gameclk, strum, intersections, buttons}; end
            5'd25: mscore = mrf[rd];
            default: ;
        endcase
        if (ewreg != 0) mrf[ewreg] = ewval;
        mpc = npc;
    endtask

    initial begin
        logic ok;
        logic exp_we, exp_wr;
        buttons = 4'b1010; intersections = 4'b0011; strum = 1'b1; gameclk = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 32'd0; mmem[i] = 32'd0; ram[i] <= 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            rf[i] <= 32'd0; mrf[i] = 32'd0;
        end
        rom[0]  = i_ins(5'd5, 1, 0, 5);
        rom[1]  = i_ins(5'd5, 2, 1, -3);
        rom[2]  = i_ins(5'd5, 5, 0, -8);
        rom[3]  = r_ins(6, 5, 5, 0, 1);
        rom[4]  = r_ins(7, 5, 1, 0, 3);
        rom[5]  = r_ins(8, 5, 7, 0, 2);
        rom[6]  = r_ins(9, 5, 0, 1, 4);
        rom[7]  = r_ins(10, 5, 0, 1, 5);
        rom[8]  = r_ins(11, 1, 2, 0, 0);
        rom[9]  = i_ins(5'd7, 2, 0, 4);
        rom[10] = i_ins(5'd8, 3, 0, 4);
        rom[11] = i_ins(5'd2, 1, 2, 1);
        rom[12] = i_ins(5'd5, 12, 0, 99);
        rom[13] = i_ins(5'd2, 1, 1, 1);
        rom[14] = i_ins(5'd5, 13, 0, 1);
        rom[15] = i_ins(5'd5, 14, 0, -1);
        rom[16] = i_ins(5'd6, 14, 13, 1);
        rom[17] = i_ins(5'd5, 12, 0, 98);
        rom[18] = j_ins(5'd3, 40);
        rom[40] = i_ins(5'd5, 15, 0, 3);
        rom[41] = i_ins(5'd4, 31, 0, 0);
        rom[19] = j_ins(5'd21, 7);
        rom[20] = j_ins(5'd22, 24);
        for (int i = 21; i < 24; i++) rom[i] = i_ins(5'd5, 12, 0, 97);
        rom[24] = i_ins(5'd5, 0, 0, 9);
        rom[25] = i_ins(5'd24, 4, 0, 0);
        rom[26] = i_ins(5'd25, 4, 0, 0);
        rom[27] = j_ins(5'd21, 0);
        rom[28] = j_ins(5'd22, 40);
        rom[29] = 32'hF800_0000;
        rom[30] = r_ins(11, 1, 2, 0, 6);
        rom[31] = i_ins(5'd5, 16, 0, 5);
        rom[32] = j_ins(5'd1, 32);
        mpc = 0; mscore = 0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc", address_imem, 32'd0);
        chk("reset_score", score, 32'd0);
        chk("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("reset_wren", {31'd0, wren}, 32'd0);
        reset = 1'b0;

        for (int n = 0; n < 33; n++) begin
            @(negedge clock);
            chk("pc", address_imem, mpc);
            chk("score", score, mscore);
            ok = 1'b1;
            for (int j = 0; j < 32; j++) if (rf[j] !== mrf[j]) ok = 1'b0;
            chk("regfile", {31'd0, ok}, 32'd1);
            chk("fetch_we", {31'd0, ctrl_writeEnable}, 32'd0);
            chk("fetch_wren", {31'd0, wren}, 32'd0);
            step(rom[mpc[11:0]]);
            for (int k = 1; k < cpi; k++) begin
                @(negedge clock);
                exp_we = k == ewph && ewreg != 0;
                exp_wr = esw && k == 2;
                chk("we", {31'd0, ctrl_writeEnable}, {31'd0, exp_we});
                if (exp_we) begin
                    chk("wreg", {27'd0, ctrl_writeReg}, {27'd0, ewreg});
                    chk("wdata", data_writeReg, ewval);
                end
                chk("wren", {31'd0, wren}, {31'd0, exp_wr});
                if (exp_wr) begin
                    chk("dmem_addr", address_dmem, eaddr);
                    chk("dmem_data", data, edata);
                end
            end
        end

        chk("lit_r1", rf[1], 32'd5);
        chk("lit_r2", rf[2], 32'd2);
        chk("lit_r3_lw", rf[3], 32'd2);
        chk("lit_sub", rf[6], 32'd0);
        chk("lit_or", rf[7], 32'hFFFF_FFFD);
        chk("lit_and", rf[8], 32'hFFFF_FFF8);
        chk("lit_sll", rf[9], 32'hFFFF_FFF0);
        chk("lit_sra", rf[10], 32'hFFFF_FFFC);
        chk("lit_badalu", rf[11], 32'd0);
        chk("lit_skipped", rf[12], 32'd0);
        chk("lit_bne_nt", rf[13], 32'd1);
        chk("lit_jal_body", rf[15], 32'd3);
        chk("lit_r31", rf[31], 32'd19);
        chk("lit_gin", rf[4], 32'h13A);
        chk("lit_score", score, 32'h13A);
        chk("lit_r16", rf[16], 32'd5);
        chk("lit_pc", address_imem, 32'd32);
        chk("wren_cycles", wren_cnt, 32'd1);

        @(negedge clock);
        reset = 1'b1;
        rom[0] = i_ins(5'd8, 20, 0, 4);
        #1;
        chk("rst1_score", score, 32'd0);
        chk("rst1_pc", address_imem, 32'd0);
        chk("rst1_we", {31'd0, ctrl_writeEnable}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("lw_fetch_pc", address_imem, 32'd0);
        @(negedge clock);
        chk("lw_exec_we", {31'd0, ctrl_writeEnable}, 32'd0);
        @(negedge clock);
        chk("lw_mem_wren", {31'd0, wren}, 32'd0);
        @(negedge clock);
        chk("lw_wb_we", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("lw_wb_reg", {27'd0, ctrl_writeReg}, 32'd20);
        chk("lw_wb_data", data_writeReg, 32'd2);
        reset = 1'b1;
        #1;
        chk("rst2_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("rst2_pc", address_imem, 32'd0);
        chk("rst2_score", score, 32'd0);
        @(posedge clock);
        #1;
        chk("rst2_no_write", rf[20], 32'd0);
        reset = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
